aes_kat_selftest: RTL and testbench

Sequential known-answer self-test engine for the AES core. It drives the combinational `Encryption` and `Decryption` datapaths through a chained run: ITER encryptions, each fed back into the next, then ITER decryptions. It checks the first ciphertext against the FIPS-197 Appendix C answer for the configured key size, and checks that the round trip restores the plaintext. Reports are registered, sticky pass flags plus a run counter, for power-on and on-demand health checks.

---
 rtl/aes_kat_pkg.sv | 151 +++++++++++++++
 rtl/Decryption.sv | 27 ++
 rtl/Encryption.sv | 28 ++
 rtl/aes_kat_fsm.sv | 74 +++++++
 rtl/aes_kat_selftest.sv | 106 ++++++++++
 tb/tb_aes_kat_selftest.sv | 136 +++++++++++++
 6 files changed

// File: rtl/aes_kat_pkg.sv
// Shared constants, FSM state encoding and AES arithmetic helpers for the
// known-answer self-test engine and its Encryption/Decryption datapaths.
package aes_kat_pkg;

   localparam logic [127:0] PLAINTEXT = 128'h00112233445566778899aabbccddeeff;
   // Longest key; shorter keys are its leading Nk words.
   localparam logic [255:0] KEY_MAX =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   localparam logic [127:0] KAT_NK4 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] KAT_NK6 = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] KAT_NK8 = 128'h8ea2b7ca516745bfeafc49904b496089;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ENC,
      ST_DEC,
      ST_CHECK,
      ST_DONE
   } state_t;

   // Word 0 is the most significant word of the packed schedule.
   typedef logic [0:59][31:0] key_sched_t;

   function automatic logic [127:0] kat_expected(input int unsigned nk);
      case (nk)
         6:       return KAT_NK6;
         8:       return KAT_NK8;
         default: return KAT_NK4;
      endcase
   endfunction

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = '0;
      x = a;
      y = b;
      for (int unsigned i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0).
   function automatic logic [7:0] ginv(input logic [7:0] a);
      logic [7:0] p, sq;
      p  = 8'h01;
      sq = a;
      for (int unsigned i = 0; i < 7; i++) begin
         sq = gmul(sq, sq);
         p  = gmul(p, sq);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
      logic [15:0] t;
      t = {b, b} << n;
      return t[15:8];
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] v;
      v = ginv(b);
      return v ^ rotl8(v, 1) ^ rotl8(v, 2) ^ rotl8(v, 3) ^ rotl8(v, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] b);
      return ginv(rotl8(b, 1) ^ rotl8(b, 3) ^ rotl8(b, 6) ^ 8'h05);
   endfunction

   // Byte i of a block, byte 0 being the most significant.
   function automatic logic [7:0] gb(input logic [127:0] s, input int unsigned i);
      return 8'(s >> (8 * (15 - i)));
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      o = '0;
      for (int unsigned i = 0; i < 16; i++)
         o = {o[119:0], (inv ? inv_sbox(gb(s, i)) : sbox(gb(s, i)))};
      return o;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      int unsigned c, r;
      o = '0;
      for (int unsigned i = 0; i < 16; i++) begin
         c = i / 4;
         r = i % 4;
         o = {o[119:0], gb(s, 4 * (inv ? (c + 4 - r) % 4 : (c + r) % 4) + r)};
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
      logic [127:0] o;
      logic [7:0]   k0, k1, k2, k3;
      int unsigned  c, r;
      o  = '0;
      k0 = inv ? 8'h0e : 8'h02;
      k1 = inv ? 8'h0b : 8'h03;
      k2 = inv ? 8'h0d : 8'h01;
      k3 = inv ? 8'h09 : 8'h01;
      for (int unsigned i = 0; i < 16; i++) begin
         c = 4 * (i / 4);
         r = i % 4;
         o = {o[119:0], gmul(gb(s, c + r), k0) ^ gmul(gb(s, c + (r + 1) % 4), k1) ^
                        gmul(gb(s, c + (r + 2) % 4), k2) ^ gmul(gb(s, c + (r + 3) % 4), k3)};
      end
      return o;
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] t);
      return {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
   endfunction

   // key holds the Nk-word key right-aligned.
   function automatic key_sched_t expand_key(input logic [255:0] key, input int unsigned nk,
                                             input int unsigned nr);
      key_sched_t  w;
      logic [31:0] t;
      logic [7:0]  rcon;
      w    = '0;
      rcon = 8'h01;
      for (int unsigned i = 0; i < 4 * (nr + 1); i++) begin
         if (i < nk) begin
            w[6'(i)] = 32'(key >> (32 * (nk - 1 - i)));
         end else begin
            t = w[6'(i - 1)];
            if (i % nk == 0) begin
               t    = sub_word({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
               rcon = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            end else if (nk > 6 && i % nk == 4) begin
               t = sub_word(t);
            end
            w[6'(i)] = w[6'(i - nk)] ^ t;
         end
      end
      return w;
   endfunction

   function automatic logic [127:0] round_key(input key_sched_t w, input int unsigned r);
      return {w[6'(4 * r)], w[6'(4 * r + 1)], w[6'(4 * r + 2)], w[6'(4 * r + 3)]};
   endfunction

endpackage

// File: rtl/Decryption.sv
// Combinational AES inverse cipher, all Nr rounds in one evaluation.
module Decryption #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic [Nk*32-1:0] i_key,
   input  logic [127:0]     i_data,
   output logic [127:0]     o_data
);
   import aes_kat_pkg::*;

   localparam int unsigned NR = Nr;

   key_sched_t   w_sched;
   logic [127:0] w_state;

   // Rounds applied in reverse, round keys consumed from Nr down to 0.
   always_comb begin
      w_sched = expand_key(256'(i_key), Nk, NR);
      w_state = i_data ^ round_key(w_sched, NR);
      for (int unsigned r = 1; r <= NR; r++) begin
         w_state = sub_bytes(shift_rows(w_state, 1'b1), 1'b1) ^ round_key(w_sched, NR - r);
         if (r != NR) w_state = mix_columns(w_state, 1'b1);
      end
      o_data = w_state;
   end
endmodule

// File: rtl/Encryption.sv
// Combinational AES forward cipher, all Nr rounds in one evaluation.
module Encryption #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic [Nk*32-1:0] i_key,
   input  logic [127:0]     i_data,
   output logic [127:0]     o_data
);
   import aes_kat_pkg::*;

   localparam int unsigned NR = Nr;

   key_sched_t   w_sched;
   logic [127:0] w_state;

   // Key schedule followed by the unrolled round sequence.
   always_comb begin
      w_sched = expand_key(256'(i_key), Nk, NR);
      w_state = i_data ^ round_key(w_sched, 0);
      for (int unsigned r = 1; r <= NR; r++) begin
         w_state = shift_rows(sub_bytes(w_state, 1'b0), 1'b0);
         if (r != NR) w_state = mix_columns(w_state, 1'b0);
         w_state = w_state ^ round_key(w_sched, r);
      end
      o_data = w_state;
   end
endmodule

// File: rtl/aes_kat_fsm.sv
// Run sequencer: IDLE -> ENC (ITER) -> DEC (ITER) -> CHECK -> DONE -> IDLE.
module aes_kat_fsm #(
   parameter int ITER = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_start,
   output logic o_accept,
   output logic o_enc,
   output logic o_dec,
   output logic o_check,
   output logic o_done,
   output logic o_first,
   output logic o_last
);
   import aes_kat_pkg::*;

   localparam logic [7:0] LAST = 8'(ITER - 1);

   state_t     r_state, w_state_next;
   logic [7:0] r_iter_cnt, w_iter_next;

   // State and iteration counter registers.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_iter_cnt <= '0;
      end else begin
         r_state    <= w_state_next;
         r_iter_cnt <= w_iter_next;
      end
   end

   // Next-state and counter update.
   always_comb begin
      w_state_next = r_state;
      w_iter_next  = r_iter_cnt;
      case (r_state)
         ST_IDLE: begin
            if (i_start) begin
               w_state_next = ST_ENC;
               w_iter_next  = '0;
            end
         end
         ST_ENC: begin
            if (r_iter_cnt == LAST) begin
               w_state_next = ST_DEC;
               w_iter_next  = '0;
            end else begin
               w_iter_next = r_iter_cnt + 8'd1;
            end
         end
         ST_DEC: begin
            if (r_iter_cnt == LAST) begin
               w_state_next = ST_CHECK;
               w_iter_next  = '0;
            end else begin
               w_iter_next = r_iter_cnt + 8'd1;
            end
         end
         ST_CHECK: w_state_next = ST_DONE;
         ST_DONE:  w_state_next = ST_IDLE;
         default:  w_state_next = ST_IDLE;
      endcase
   end

   assign o_accept = (r_state == ST_IDLE) && i_start;
   assign o_enc    = (r_state == ST_ENC);
   assign o_dec    = (r_state == ST_DEC);
   assign o_check  = (r_state == ST_CHECK);
   assign o_done   = (r_state == ST_DONE);
   assign o_first  = (r_iter_cnt == '0);
   assign o_last   = (r_iter_cnt == LAST);
endmodule

// File: rtl/aes_kat_selftest.sv
// AES known-answer self-test: chained ITER encryptions then ITER decryptions,
// KAT check on the first ciphertext and round-trip check on the result.
// Optional macro AES_SELFTEST_AUTO_EN: launches one run right after reset.
module aes_kat_selftest #(
   parameter int Nk   = 4,
   parameter int Nr   = 10,
   parameter int ITER = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       inject_err,
   output logic       busy,
   output logic       done,
   output logic       pass_encrypt,
   output logic       pass_decrypt,
   output logic [7:0] run_cnt
);
   import aes_kat_pkg::*;

   if (!((Nk == 4 && Nr == 10) || (Nk == 6 && Nr == 12) || (Nk == 8 && Nr == 14))) begin : g_bad_key
      $error("aes_kat_selftest: unsupported Nk/Nr pair");
   end
   if (ITER < 1 || ITER > 255) begin : g_bad_iter
      $error("aes_kat_selftest: ITER must be 1..255");
   end

   localparam logic [Nk*32-1:0] KEY = KEY_MAX[255 -: Nk*32];
   localparam logic [127:0]     KAT = kat_expected(Nk);

   logic         w_start, w_inject;
   logic         w_accept, w_enc, w_dec, w_check, w_done, w_first, w_last;
   logic [127:0] w_enc_out, w_dec_out;
   logic [127:0] r_data;
   logic         r_enc_ok, r_inject, r_pass_enc, r_pass_dec;
   logic [7:0]   r_run_cnt;

`ifdef AES_SELFTEST_AUTO_EN
   logic r_auto;

   // One-shot implicit start, armed by reset.
   always_ff @(posedge clk) begin
      if (reset) r_auto <= 1'b1;
      else       r_auto <= 1'b0;
   end

   assign w_start  = start | r_auto;
   assign w_inject = inject_err & ~r_auto;
`else
   assign w_start  = start;
   assign w_inject = inject_err;
`endif

   aes_kat_fsm #(.ITER(ITER)) u_fsm (
      .i_clk    (clk),
      .i_reset  (reset),
      .i_start  (w_start),
      .o_accept (w_accept),
      .o_enc    (w_enc),
      .o_dec    (w_dec),
      .o_check  (w_check),
      .o_done   (w_done),
      .o_first  (w_first),
      .o_last   (w_last)
   );

   Encryption #(.Nk(Nk), .Nr(Nr)) u_enc (.i_key(KEY), .i_data(r_data), .o_data(w_enc_out));
   Decryption #(.Nk(Nk), .Nr(Nr)) u_dec (.i_key(KEY), .i_data(r_data), .o_data(w_dec_out));

   // Data register, KAT result and sticky report flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_data     <= '0;
         r_enc_ok   <= 1'b0;
         r_inject   <= 1'b0;
         r_pass_enc <= 1'b0;
         r_pass_dec <= 1'b0;
         r_run_cnt  <= '0;
      end else begin
         if (w_accept) begin
            r_data     <= PLAINTEXT;
            r_enc_ok   <= 1'b0;
            r_pass_enc <= 1'b0;
            r_pass_dec <= 1'b0;
            r_inject   <= w_inject;
         end
         if (w_enc) begin
            // The fault flip rides on the last ENC edge, i.e. on DEC entry.
            r_data <= w_enc_out ^ {127'b0, w_last & r_inject};
            if (w_first) r_enc_ok <= (w_enc_out == KAT);
         end
         if (w_dec) r_data <= w_dec_out;
         if (w_check) begin
            r_pass_enc <= r_enc_ok;
            r_pass_dec <= (r_data == PLAINTEXT);
            if (r_run_cnt != 8'hff) r_run_cnt <= r_run_cnt + 8'd1;
         end
      end
   end

   assign busy         = w_enc | w_dec | w_check;
   assign done         = w_done;
   assign pass_encrypt = r_pass_enc;
   assign pass_decrypt = r_pass_dec;
   assign run_cnt      = r_run_cnt;
endmodule

// File: tb/tb_aes_kat_selftest.sv
// Bench for aes_kat_selftest: three key sizes run in lockstep from shared
// stimulus; a cycle-level run model feeds an expectation queue and a
// per-cycle busy map, and a monitor compares the DUT outputs against them.
module tb_aes_kat_selftest;

   localparam int ITER    = 4;
   localparam int RUN_LEN = 2 * ITER + 2;
   localparam int MAXCYC  = 8192;

   logic       clk = 1'b0;
   logic       reset = 1'b1, start = 1'b0, inject_err = 1'b0;
   logic [2:0] busy, done, pe, pd;
   logic [7:0] rc0, rc1, rc2;

   aes_kat_selftest #(.Nk(4), .Nr(10), .ITER(ITER)) u_dut_nk4 (
      .clk(clk), .reset(reset), .start(start), .inject_err(inject_err),
      .busy(busy[0]), .done(done[0]), .pass_encrypt(pe[0]), .pass_decrypt(pd[0]), .run_cnt(rc0));
   aes_kat_selftest #(.Nk(6), .Nr(12), .ITER(ITER)) u_dut_nk6 (
      .clk(clk), .reset(reset), .start(start), .inject_err(inject_err),
      .busy(busy[1]), .done(done[1]), .pass_encrypt(pe[1]), .pass_decrypt(pd[1]), .run_cnt(rc1));
   aes_kat_selftest #(.Nk(8), .Nr(14), .ITER(ITER)) u_dut_nk8 (
      .clk(clk), .reset(reset), .start(start), .inject_err(inject_err),
      .busy(busy[2]), .done(done[2]), .pass_encrypt(pe[2]), .pass_decrypt(pd[2]), .run_cnt(rc2));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int cyc;
      bit is_done;
      bit pe;
      bit pd;
      int rc;
   } exp_t;

   exp_t q[$];
   bit   exp_busy[MAXCYC];
   int   m_runs = 0, m_since_reset = 0, next_ok = 0, mon_start = -1;
   int   n_cmp = 0, n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s @cycle %0d: got %h, expected %h", nm, cyc, act, exp);
      end
   endtask

   // Run-level model: a start in cycle n is taken when the engine is idle;
   // the run reports 2*ITER+2 cycles later and is busy in between.
   task automatic model_step(input int n, input bit s, input bit inj, input bit rst);
      if (rst) begin
         while (q.size() > 0 && q[$].cyc > n) void'(q.pop_back());
         for (int k = n + 1; k <= n + RUN_LEN + 1 && k < MAXCYC; k++) exp_busy[k] = 1'b0;
         m_runs = 0;
         m_since_reset = 0;
         next_ok = n + 1;
         if (mon_start < 0) mon_start = n + 1;
         q.push_back('{cyc: n + 1, is_done: 1'b0, pe: 1'b0, pd: 1'b0, rc: 0});
      end else if (mon_start >= 0 && s && n >= next_ok) begin
         m_runs = (m_runs < 255) ? m_runs + 1 : 255;
         m_since_reset++;
         q.push_back('{cyc: n + RUN_LEN, is_done: 1'b1, pe: 1'b1, pd: !inj, rc: m_runs});
         for (int k = n + 1; k <= n + RUN_LEN - 1 && k < MAXCYC; k++) exp_busy[k] = 1'b1;
         next_ok = n + RUN_LEN + 1;
      end
   endtask

   task automatic drive(input bit s, input bit inj, input bit rst);
      @(negedge clk);
      start      = s;
      inject_err = inj;
      reset      = rst;
      model_step(cyc, s, inj, rst);
   endtask

   // Monitor: samples 2 time units after the falling edge.
   initial begin
      exp_t e;
      bit   eb, ed;
      forever begin
         @(negedge clk);
         #2;
         if (mon_start >= 0 && cyc >= mon_start && cyc < MAXCYC) begin
            eb = exp_busy[cyc];
            ed = (q.size() > 0 && q[0].cyc == cyc && q[0].is_done);
            chk("busy", 32'(busy), {29'b0, {3{eb}}});
            chk("done", 32'(done), {29'b0, {3{ed}}});
            while (q.size() > 0 && q[0].cyc <= cyc) begin
               e = q.pop_front();
               chk(e.is_done ? "done_pass_encrypt" : "reset_pass_encrypt", 32'(pe), {29'b0, {3{e.pe}}});
               chk(e.is_done ? "done_pass_decrypt" : "reset_pass_decrypt", 32'(pd), {29'b0, {3{e.pd}}});
               chk("run_cnt_nk4", 32'(rc0), e.rc);
               chk("run_cnt_nk6", 32'(rc1), e.rc);
               chk("run_cnt_nk8", 32'(rc2), e.rc);
            end
         end
      end
   end

   // Stimulus.
   initial begin
      int guard;
      repeat (3) drive(1'b0, 1'b0, 1'b1);
      repeat (3) drive(1'b0, 1'b0, 1'b0);
      // Single clean run, then an injected run.
      drive(1'b1, 1'b0, 1'b0);
      repeat (RUN_LEN + 2) drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0);
      repeat (RUN_LEN + 2) drive(1'b0, 1'b0, 1'b0);
      // Reset in the second DEC cycle aborts the run.
      drive(1'b1, 1'b0, 1'b0);
      repeat (ITER + 1) drive(1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 1'b1);
      repeat (3) drive(1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b0);
      repeat (RUN_LEN + 2) drive(1'b0, 1'b0, 1'b0);
      // Start held high: back-to-back runs, no queued starts.
      repeat (30) drive(1'b1, 1'b0, 1'b0);
      // Random traffic until run_cnt has saturated.
      guard = 0;
      while (m_since_reset < 265 && guard < 7000) begin
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0, 1'b0);
         guard++;
      end
      repeat (RUN_LEN + 3) drive(1'b0, 1'b0, 1'b0);
      #3;
      chk("drained_runs", 32'(q.size()), 32'd0);
      chk("saturation_reached", 32'(m_since_reset >= 256), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule
